// File: rtl/depkt_pkg.sv
// Shared header geometry and state encoding for the depacketizer (and the TX packetizer).
package depkt_pkg;

  localparam int HDR_PRE   = 224;
  localparam int HDR_MARK  = 32;
  localparam int HDR_MOD   = 8;
  localparam int HDR_LEN   = 16;
  localparam int HDR_TAIL  = 40;
  localparam int HDR_TOTAL = 320;

  // Header symbol indices at which each field is complete.
  localparam logic [8:0] K_MARK_FIRST = 9'(HDR_PRE + 1);
  localparam logic [8:0] K_MARK_END   = 9'(HDR_PRE + HDR_MARK - 1);
  localparam logic [8:0] K_MOD_END    = 9'(HDR_PRE + HDR_MARK + HDR_MOD - 1);
  localparam logic [8:0] K_LEN_END    = 9'(HDR_PRE + HDR_MARK + HDR_MOD + HDR_LEN - 1);
  localparam logic [8:0] K_TAIL_END   = 9'(HDR_TOTAL - 1);

  typedef enum logic [6:0] {
    HUNT  = 7'b0000001,
    MARK  = 7'b0000010,
    MOD   = 7'b0000100,
    LEN   = 7'b0001000,
    TAIL  = 7'b0010000,
    PLD   = 7'b0100000,
    DRAIN = 7'b1000000
  } state_t;

  function automatic logic [15:0] payloadSymbs(input logic isBpsk, input logic [15:0] lenBits);
    return isBpsk ? lenBits : {1'b0, lenBits[15:1]};
  endfunction

endpackage

// File: rtl/depkt_if.sv
// AXI-stream style symbol bundle used on both sides of the depacketizer.
interface depkt_if #(parameter int BYTES = 1);
  logic [BYTES*8-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic               tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/depkt_sync_det.sv
// Preamble run counter and phase-reversal marker detector.
// Build option: DEPKT_PHASE_INV_EN also locks on an inverted (repeated '0') marker.
module depkt_sync_det
  import depkt_pkg::*;
#(
  parameter int MIN_ALT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_hunt,
  input  logic i_evt,
  input  logic i_bit,
  output logic o_lock,
  output logic o_inv
);

  localparam logic [7:0] MIN_RUN = 8'(MIN_ALT);

  logic [7:0] r_run;
  logic       r_prev;
  logic       r_inv;
  logic       w_repeat;
  logic       w_polarityOk;

  assign w_repeat = (i_bit == r_prev);

`ifdef DEPKT_PHASE_INV_EN
  assign w_polarityOk = 1'b1;
`else
  assign w_polarityOk = i_bit;
`endif

  assign o_lock = i_hunt & i_evt & w_repeat & w_polarityOk & (r_run >= MIN_RUN);
  assign o_inv  = r_inv;

  // The run restarts from zero every time the receiver falls back to hunting.
  always_ff @(posedge clk) begin
    if (rst || !i_hunt) begin
      r_run  <= 8'd0;
      r_prev <= 1'b0;
    end else if (i_evt) begin
      r_prev <= i_bit;
      if (w_repeat)
        r_run <= 8'd1;
      else if (r_run != 8'hFF)
        r_run <= r_run + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_inv <= 1'b0;
    else if (i_hunt)
      r_inv <= o_lock & ~i_bit;
  end

endmodule

// File: rtl/depacketizer.sv
// Hunts the 320-symbol BPSK header, decodes modulation and length, then forwards the payload as an AXIS packet.
module depacketizer
  import depkt_pkg::*;
#(
  parameter int BYTES   = 1,
  parameter int MIN_ALT = 64,
  parameter int MAX_ERR = 2
) (
  input  logic        clk,
  input  logic        rst,
  depkt_if.slave      i_sym,
  depkt_if.master     o_pld,
  output logic [15:0] o_payload_length,
  output logic        o_hdr_vld,
  output logic        o_hdr_err
);

  localparam logic [5:0] MAX_ERR_C = 6'(MAX_ERR);

  state_t             r_state;
  logic [8:0]         r_k;
  logic [5:0]         r_errCnt;
  logic [3:0]         r_modOnes;
  logic               r_isBpsk;
  logic [15:0]        r_len;
  logic [15:0]        r_pldSymbs;
  logic [15:0]        r_pldCnt;
  logic [BYTES*8-1:0] r_tdata;
  logic               r_tvalid;
  logic               r_tlast;
  logic               r_tuser;
  logic [15:0]        r_payloadLength;
  logic               r_hdrVld;
  logic               r_hdrErr;

  logic        w_hunt;
  logic        w_ready;
  logic        w_evt;
  logic        w_lock;
  logic        w_inv;
  logic        w_bit;
  logic        w_mis;
  logic        w_modOne;
  logic        w_outFire;
  logic [5:0]  w_errTotal;
  logic [3:0]  w_modTotal;
  logic [15:0] w_pldSymbs;

  assign w_hunt     = (r_state == HUNT);
  assign w_ready    = (r_state == PLD) ? (o_pld.tready | ~r_tvalid) : 1'b1;
  assign w_evt      = i_sym.tvalid & w_ready;
  assign w_bit      = i_sym.tdata[0] ^ w_inv;
  assign w_mis      = (w_bit == r_k[0]);
  assign w_modOne   = w_bit ^ r_k[0];
  assign w_outFire  = r_tvalid & o_pld.tready;
  assign w_errTotal = r_errCnt + {5'd0, w_mis};
  assign w_modTotal = r_modOnes + {3'd0, w_modOne};
  assign w_pldSymbs = payloadSymbs(r_isBpsk, r_len);

  depkt_sync_det #(.MIN_ALT(MIN_ALT)) u_syncDet (
    .clk    (clk),
    .rst    (rst),
    .i_hunt (w_hunt),
    .i_evt  (w_evt),
    .i_bit  (i_sym.tdata[0]),
    .o_lock (w_lock),
    .o_inv  (w_inv)
  );

  assign i_sym.tready     = w_ready;
  assign o_pld.tdata      = r_tdata;
  assign o_pld.tvalid     = r_tvalid;
  assign o_pld.tlast      = r_tlast;
  assign o_pld.tuser      = r_tuser;
  assign o_payload_length = r_payloadLength;
  assign o_hdr_vld        = r_hdrVld;
  assign o_hdr_err        = r_hdrErr;

  // r_k always holds the header index of the next symbol to arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= HUNT;
      r_k             <= 9'd0;
      r_errCnt        <= 6'd0;
      r_modOnes       <= 4'd0;
      r_isBpsk        <= 1'b0;
      r_len           <= 16'd0;
      r_pldSymbs      <= 16'd0;
      r_pldCnt        <= 16'd0;
      r_tdata         <= '0;
      r_tvalid        <= 1'b0;
      r_tlast         <= 1'b0;
      r_tuser         <= 1'b1;
      r_payloadLength <= 16'd0;
      r_hdrVld        <= 1'b0;
      r_hdrErr        <= 1'b0;
    end else begin
      r_hdrVld <= 1'b0;
      r_hdrErr <= 1'b0;
      if (w_outFire) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      case (r_state)
        HUNT: begin
          if (w_lock) begin
            r_state  <= MARK;
            r_k      <= K_MARK_FIRST;
            r_errCnt <= 6'd0;
          end
        end
        MARK: begin
          if (w_evt) begin
            r_k      <= r_k + 9'd1;
            r_errCnt <= w_errTotal;
            if (r_k == K_MARK_END) begin
              if (w_errTotal > MAX_ERR_C) begin
                r_hdrErr <= 1'b1;
                r_state  <= HUNT;
              end else begin
                r_modOnes <= 4'd0;
                r_state   <= MOD;
              end
            end
          end
        end
        MOD: begin
          if (w_evt) begin
            r_k       <= r_k + 9'd1;
            r_modOnes <= w_modTotal;
            if (r_k == K_MOD_END) begin
              r_isBpsk <= (w_modTotal >= 4'd4);
              r_state  <= LEN;
            end
          end
        end
        LEN: begin
          if (w_evt) begin
            r_k   <= r_k + 9'd1;
            r_len <= {r_len[14:0], w_bit};
            if (r_k == K_LEN_END)
              r_state <= TAIL;
          end
        end
        TAIL: begin
          if (w_evt) begin
            r_k <= r_k + 9'd1;
            if (r_k == K_TAIL_END) begin
              if (w_pldSymbs == 16'd0) begin
                r_hdrErr <= 1'b1;
                r_state  <= HUNT;
              end else begin
                r_hdrVld        <= 1'b1;
                r_payloadLength <= r_len;
                r_tuser         <= r_isBpsk;
                r_pldSymbs      <= w_pldSymbs;
                r_pldCnt        <= 16'd0;
                r_state         <= PLD;
              end
            end
          end
        end
        PLD: begin
          if (w_evt) begin
            r_tdata  <= i_sym.tdata ^ {(BYTES*8){w_inv}};
            r_tvalid <= 1'b1;
            r_pldCnt <= r_pldCnt + 16'd1;
            if (r_pldCnt == r_pldSymbs - 16'd1) begin
              r_tlast <= 1'b1;
              r_state <= DRAIN;
            end else begin
              r_tlast <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (w_outFire)
            r_state <= HUNT;
        end
        default: r_state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_depacketizer.sv
// Directed self-checking bench for depacketizer: header hunt, field decode, payload framing, error paths.
module tb_depacketizer;

  logic        clk;
  logic        rst;
  logic [15:0] payloadLength;
  logic        hdrVld;
  logic        hdrErr;
  logic        toggleRdy;

  int checks;
  int errors;
  int vldCount;
  int errPulseCount;

  logic [7:0] gotData[$];
  logic       gotLast[$];
  logic       gotUser[$];

  depkt_if #(.BYTES(1)) symIf ();
  depkt_if #(.BYTES(1)) pldIf ();

  depacketizer #(.BYTES(1), .MIN_ALT(64), .MAX_ERR(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_sym            (symIf),
    .o_pld            (pldIf),
    .o_payload_length (payloadLength),
    .o_hdr_vld        (hdrVld),
    .o_hdr_err        (hdrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) pldIf.tready = toggleRdy ? ~pldIf.tready : 1'b1;

  // Beats are captured half a cycle early; a valid&ready pair here handshakes at the next rising edge.
  always @(negedge clk) begin
    #3;
    if (rst === 1'b0) begin
      if (pldIf.tvalid === 1'b1 && pldIf.tready === 1'b1) begin
        gotData.push_back(pldIf.tdata);
        gotLast.push_back(pldIf.tlast);
        gotUser.push_back(pldIf.tuser);
      end
      if (hdrVld === 1'b1) vldCount++;
      if (hdrErr === 1'b1) errPulseCount++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    logic acc;
    int   guard;
    symIf.tdata  = d;
    symIf.tvalid = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 64) begin
      #1;
      acc = symIf.tready;
      @(negedge clk);
      guard++;
    end
    symIf.tvalid = 1'b0;
    if (!acc) checkOutput("symAccept", 32'd0, 32'd1);
  endtask

  task automatic sendHdrSyms(input logic bpsk, input logic [15:0] lenBits, input int nErr,
                             input logic inv, input int kFrom, input int kTo);
    logic b;
    for (int k = kFrom; k <= kTo; k++) begin
      if (k < 224)      b = k[0];
      else if (k < 256) b = ~k[0] ^ ((k >= 226) && (k < 226 + nErr));
      else if (k < 264) b = bpsk ^ k[0];
      else if (k < 280) b = lenBits[279 - k];
      else              b = k[0];
      applyStimulus({7'd0, b ^ inv});
    end
  endtask

  task automatic sendPayload(input int n, input logic [7:0] base, input logic inv);
    for (int i = 0; i < n; i++)
      applyStimulus((base + 8'(i)) ^ {8{inv}});
  endtask

  task automatic clearMon();
    gotData.delete();
    gotLast.delete();
    gotUser.delete();
    vldCount      = 0;
    errPulseCount = 0;
  endtask

  task automatic waitIdle(input string tag);
    int guard;
    guard = 0;
    while (pldIf.tvalid !== 1'b0 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    repeat (2) @(negedge clk);
    #1;
    checkOutput({tag, "_idle"}, {31'd0, pldIf.tvalid}, 32'd0);
  endtask

  task automatic checkPacket(input string tag, input int n, input logic [7:0] base, input logic userExp);
    int dErr, uErr, lCnt, lIdx;
    dErr = 0; uErr = 0; lCnt = 0; lIdx = -1;
    for (int i = 0; i < gotData.size(); i++) begin
      if (gotData[i] !== base + 8'(i)) dErr++;
      if (gotUser[i] !== userExp) uErr++;
      if (gotLast[i] === 1'b1) begin
        lCnt++;
        lIdx = i;
      end
    end
    checkOutput({tag, "_beats"}, gotData.size(), n);
    checkOutput({tag, "_dataErrs"}, dErr, 0);
    checkOutput({tag, "_tuserErrs"}, uErr, 0);
    checkOutput({tag, "_lastCount"}, lCnt, 1);
    checkOutput({tag, "_lastIndex"}, lIdx, n - 1);
  endtask

  initial begin
    int lCnt;
    checks = 0; errors = 0;
    toggleRdy    = 1'b0;
    pldIf.tready = 1'b1;
    symIf.tdata  = 8'd0;
    symIf.tvalid = 1'b0;
    symIf.tlast  = 1'b0;
    symIf.tuser  = 1'b0;
    clearMon();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;

    $display("[TB] reset values");
    checkOutput("rst_inTready", {31'd0, symIf.tready}, 32'd1);
    checkOutput("rst_outValid", {31'd0, pldIf.tvalid}, 32'd0);
    checkOutput("rst_outLast", {31'd0, pldIf.tlast}, 32'd0);
    checkOutput("rst_outData", {24'd0, pldIf.tdata}, 32'd0);
    checkOutput("rst_outUser", {31'd0, pldIf.tuser}, 32'd1);
    checkOutput("rst_hdrVld", {31'd0, hdrVld}, 32'd0);
    checkOutput("rst_hdrErr", {31'd0, hdrErr}, 32'd0);
    checkOutput("rst_length", {16'd0, payloadLength}, 32'd0);

    $display("[TB] clean BPSK header, len=16");
    clearMon();
    sendHdrSyms(1'b1, 16'd16, 0, 1'b0, 0, 318);
    #1;
    checkOutput("bpsk16_vldEarly", {31'd0, hdrVld}, 32'd0);
    sendHdrSyms(1'b1, 16'd16, 0, 1'b0, 319, 319);
    #1;
    checkOutput("bpsk16_vldAt319", {31'd0, hdrVld}, 32'd1);
    checkOutput("bpsk16_length", {16'd0, payloadLength}, 32'd16);
    checkOutput("bpsk16_tuser", {31'd0, pldIf.tuser}, 32'd1);
    sendPayload(16, 8'h10, 1'b0);
    waitIdle("bpsk16");
    checkPacket("bpsk16", 16, 8'h10, 1'b1);
    checkOutput("bpsk16_vldCount", vldCount, 1);

    $display("[TB] QPSK header, len=33");
    clearMon();
    sendHdrSyms(1'b0, 16'd33, 0, 1'b0, 0, 319);
    #1;
    checkOutput("qpsk33_length", {16'd0, payloadLength}, 32'd33);
    checkOutput("qpsk33_tuser", {31'd0, pldIf.tuser}, 32'd0);
    sendPayload(16, 8'h30, 1'b0);
    waitIdle("qpsk33");
    checkPacket("qpsk33", 16, 8'h30, 1'b0);

    $display("[TB] BPSK len=1 followed immediately by len=2");
    clearMon();
    sendHdrSyms(1'b1, 16'd1, 0, 1'b0, 0, 319);
    sendPayload(1, 8'h50, 1'b0);
    sendHdrSyms(1'b1, 16'd2, 0, 1'b0, 0, 319);
    sendPayload(2, 8'h51, 1'b0);
    waitIdle("len1");
    checkOutput("len1_beats", gotData.size(), 3);
    checkOutput("len1_first", {31'd0, gotLast[0]}, 32'd1);
    checkOutput("len1_mid", {31'd0, gotLast[1]}, 32'd0);
    checkOutput("len1_second", {31'd0, gotLast[2]}, 32'd1);
    checkOutput("len1_data2", {24'd0, gotData[2]}, 32'h52);
    checkOutput("len1_vldCount", vldCount, 2);

    $display("[TB] marker with 2 errors locks");
    clearMon();
    sendHdrSyms(1'b1, 16'd3, 2, 1'b0, 0, 319);
    #1;
    checkOutput("mark2_vld", {31'd0, hdrVld}, 32'd1);
    sendPayload(3, 8'h60, 1'b0);
    waitIdle("mark2");
    checkPacket("mark2", 3, 8'h60, 1'b1);
    checkOutput("mark2_errPulses", errPulseCount, 0);

    $display("[TB] marker with 3 errors rejected");
    clearMon();
    sendHdrSyms(1'b1, 16'd3, 3, 1'b0, 0, 255);
    #1;
    checkOutput("mark3_err", {31'd0, hdrErr}, 32'd1);
    checkOutput("mark3_inTready", {31'd0, symIf.tready}, 32'd1);
    @(negedge clk);
    #1;
    checkOutput("mark3_errPulses", errPulseCount, 1);
    checkOutput("mark3_vldCount", vldCount, 0);

    $display("[TB] payload with out_tready toggling");
    clearMon();
    sendHdrSyms(1'b1, 16'd10, 0, 1'b0, 0, 319);
    toggleRdy = 1'b1;
    sendPayload(10, 8'h20, 1'b0);
    waitIdle("toggle");
    toggleRdy = 1'b0;
    @(negedge clk);
    checkPacket("toggle", 10, 8'h20, 1'b1);

    $display("[TB] zero length header");
    clearMon();
    sendHdrSyms(1'b1, 16'd0, 0, 1'b0, 0, 319);
    #1;
    checkOutput("len0_err", {31'd0, hdrErr}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("len0_vldCount", vldCount, 0);
    checkOutput("len0_beats", gotData.size(), 0);
    checkOutput("len0_outValid", {31'd0, pldIf.tvalid}, 32'd0);

    $display("[TB] reset at payload beat 5");
    clearMon();
    sendHdrSyms(1'b1, 16'd16, 0, 1'b0, 0, 319);
    sendPayload(5, 8'h70, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    lCnt = 0;
    foreach (gotLast[i]) if (gotLast[i] === 1'b1) lCnt++;
    checkOutput("midRst_outValid", {31'd0, pldIf.tvalid}, 32'd0);
    checkOutput("midRst_outLast", {31'd0, pldIf.tlast}, 32'd0);
    checkOutput("midRst_outUser", {31'd0, pldIf.tuser}, 32'd1);
    checkOutput("midRst_outData", {24'd0, pldIf.tdata}, 32'd0);
    checkOutput("midRst_length", {16'd0, payloadLength}, 32'd0);
    checkOutput("midRst_inTready", {31'd0, symIf.tready}, 32'd1);
    checkOutput("midRst_noLast", lCnt, 0);
    clearMon();
    sendHdrSyms(1'b1, 16'd4, 0, 1'b0, 0, 319);
    sendPayload(4, 8'h80, 1'b0);
    waitIdle("afterRst");
    checkPacket("afterRst", 4, 8'h80, 1'b1);

    $display("[TB] phase-inverted stream");
    clearMon();
    sendHdrSyms(1'b1, 16'd4, 0, 1'b1, 0, 319);
    sendPayload(4, 8'h90, 1'b1);
    waitIdle("inv");
`ifdef DEPKT_PHASE_INV_EN
    checkOutput("inv_vldCount", vldCount, 1);
    checkOutput("inv_length", {16'd0, payloadLength}, 32'd4);
    checkPacket("inv", 4, 8'h90, 1'b1);
`else
    checkOutput("inv_vldCount", vldCount, 0);
    checkOutput("inv_beats", gotData.size(), 0);
    checkOutput("inv_length", {16'd0, payloadLength}, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
